// File: rtl/ahb_cmd_master.sv
// AHB-Lite command master: turns single/incrementing-burst commands into
// pipelined AHB-Lite transfers with a write-data pop strobe and read-data strobe.
module ahb_cmd_master #(
    parameter int unsigned ADDR_INC = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [31:0] wdata,
    output logic        wdata_ready,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_PIPE,
        ST_LAST,
        ST_ERR
    } state_t;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]  HTRANS_SEQ    = 2'b11;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam logic [2:0]  HBURST_INCR   = 3'b001;
    localparam logic [31:0] ADDR_MASK     = 32'hFFFF_FFFC;
    localparam logic [31:0] INC           = 32'(ADDR_INC);

    state_t      state_reg;
    logic [31:0] haddr_reg;
    logic [1:0]  htrans_reg;
    logic        hwrite_reg;
    logic [2:0]  hburst_reg;
    logic [31:0] hwdata_reg;
    logic [3:0]  beats_left_reg;
    logic        cmd_ready_reg;
    logic [31:0] rdata_reg;
    logic        rdata_valid_reg;
    logic        done_reg;
    logic        err_reg;

    logic [31:0] haddr_next;
    logic        addr_accept;

    // Only ADDR_INC = 4 is meaningful: HSIZE is fixed to a word.
    assign haddr_next = haddr_reg + INC;

    // The pop strobe must coincide with the address-phase acceptance edge so a
    // show-ahead source can advance in time for a zero-wait next beat; it is
    // therefore qualified by HREADY rather than registered.
    assign addr_accept = ((state_reg == ST_ADDR) || (state_reg == ST_PIPE)) && HREADY && !HRESP;
    assign wdata_ready = addr_accept && hwrite_reg;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg       <= ST_IDLE;
            haddr_reg       <= '0;
            htrans_reg      <= HTRANS_IDLE;
            hwrite_reg      <= 1'b0;
            hburst_reg      <= HBURST_SINGLE;
            hwdata_reg      <= '0;
            beats_left_reg  <= '0;
            cmd_ready_reg   <= 1'b1;
            rdata_reg       <= '0;
            rdata_valid_reg <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            rdata_valid_reg <= 1'b0;
            done_reg        <= 1'b0;
            if (wdata_ready) begin
                hwdata_reg <= wdata;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_reg      <= ST_ADDR;
                        htrans_reg     <= HTRANS_NONSEQ;
                        haddr_reg      <= cmd_addr & ADDR_MASK;
                        hwrite_reg     <= cmd_write;
                        hburst_reg     <= (cmd_len == 4'd0) ? HBURST_SINGLE : HBURST_INCR;
                        beats_left_reg <= cmd_len;
                        cmd_ready_reg  <= 1'b0;
                        err_reg        <= 1'b0;
                    end
                end
                ST_ADDR, ST_PIPE: begin
                    if (HRESP && !HREADY) begin
                        // First error cycle: withdraw the pending address.
                        htrans_reg <= HTRANS_IDLE;
                        state_reg  <= ST_ERR;
                    end else if (HRESP) begin
                        htrans_reg    <= HTRANS_IDLE;
                        err_reg       <= 1'b1;
                        done_reg      <= 1'b1;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else if (HREADY) begin
                        if ((state_reg == ST_PIPE) && !hwrite_reg) begin
                            rdata_reg       <= HRDATA;
                            rdata_valid_reg <= 1'b1;
                        end
                        if (beats_left_reg != 4'd0) begin
                            haddr_reg      <= haddr_next;
                            htrans_reg     <= HTRANS_SEQ;
                            beats_left_reg <= beats_left_reg - 4'd1;
                            state_reg      <= ST_PIPE;
                        end else begin
                            htrans_reg <= HTRANS_IDLE;
                            state_reg  <= ST_LAST;
                        end
                    end
                end
                ST_LAST: begin
                    if (HRESP && !HREADY) begin
                        state_reg <= ST_ERR;
                    end else if (HREADY) begin
                        if (HRESP) begin
                            err_reg <= 1'b1;
                        end else if (!hwrite_reg) begin
                            rdata_reg       <= HRDATA;
                            rdata_valid_reg <= 1'b1;
                        end
                        done_reg      <= 1'b1;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (HREADY) begin
                        err_reg       <= 1'b1;
                        done_reg      <= 1'b1;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    htrans_reg    <= HTRANS_IDLE;
                    cmd_ready_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_reg;
    assign rdata       = rdata_reg;
    assign rdata_valid = rdata_valid_reg;
    assign done        = done_reg;
    assign err         = err_reg;
    assign HADDR       = haddr_reg;
    assign HTRANS      = htrans_reg;
    assign HWRITE      = hwrite_reg;
    assign HSIZE       = 3'b010;
    assign HBURST      = hburst_reg;
    assign HWDATA      = hwdata_reg;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: a scripted per-cycle slave response table
// drives the bus, and recorded observations are compared to hand-computed values.
module tb_ahb_cmd_master;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [31:0] wdata = '0;
    logic        wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    int checks = 0;
    int errors = 0;

    // Per-cycle observations (index 31 is the idle cycle before a command).
    logic [1:0]  o_htrans [32];
    logic [31:0] o_haddr [32], o_hwdata [32], o_rdata [32];
    logic [2:0]  o_hburst [32];
    logic        o_hwrite [32], o_rv [32], o_done [32], o_err [32], o_ready [32], o_pop [32];
    // Per-cycle slave response script.
    logic        t_rdy [32], t_resp [32];
    logic [31:0] t_rdata [32];
    logic [31:0] wq [16];
    int          wptr = 0;
    int          n_pop, n_rv, n_done;

    ahb_cmd_master #(.ADDR_INC(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic cycle(input logic rdy, input logic resp, input logic [31:0] rd, input int c);
        @(negedge HCLK);
        o_htrans[c] = HTRANS;  o_haddr[c] = HADDR;   o_hwrite[c] = HWRITE; o_hburst[c] = HBURST;
        o_hwdata[c] = HWDATA;  o_rv[c] = rdata_valid; o_rdata[c] = rdata;  o_done[c] = done;
        o_err[c] = err;        o_ready[c] = cmd_ready;
        HREADY = rdy; HRESP = resp; HRDATA = rd; wdata = wq[wptr];
        #1;
        o_pop[c] = wdata_ready;
        if (wdata_ready === 1'b1 && wptr < 15) wptr++;
    endtask

    task automatic clear_tables();
        for (int c = 0; c < 32; c++) begin
            t_rdy[c] = 1'b1; t_resp[c] = 1'b0; t_rdata[c] = 32'hDEAD_0000 + 32'(c);
        end
    endtask

    task automatic start_cmd(input logic w, input logic [31:0] a, input logic [3:0] l);
        cycle(1'b1, 1'b0, 32'h0, 31);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        wptr = 0;
    endtask

    task automatic run(input int n, input int vkeep);
        n_pop = 0; n_rv = 0; n_done = 0;
        for (int c = 0; c < n; c++) begin
            cycle(t_rdy[c], t_resp[c], t_rdata[c], c);
            if (c == vkeep) cmd_valid = 1'b0;
            if (o_pop[c] === 1'b1) n_pop++;
            if (o_rv[c] === 1'b1) n_rv++;
            if (o_done[c] === 1'b1) n_done++;
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (2) @(negedge HCLK);
        checks++; if ({HTRANS, HADDR, HWRITE, HBURST, HWDATA} !== '0) begin errors++;
            $display("FAIL reset_bus: got %h expected 0", {HTRANS, HADDR, HWRITE, HBURST, HWDATA}); end
        checks++; if ({rdata, rdata_valid, wdata_ready, done, err} !== '0) begin errors++;
            $display("FAIL reset_user: got %h expected 0", {rdata, rdata_valid, wdata_ready, done, err}); end
        checks++; if (HSIZE !== 3'b010) begin errors++;
            $display("FAIL reset_hsize: got %b expected 010", HSIZE); end
        HRESET = 1'b0;
        @(negedge HCLK);
        checks++; if (cmd_ready !== 1'b1 || HTRANS !== T_IDLE) begin errors++;
            $display("FAIL reset_release: cmd_ready=%b HTRANS=%b expected 1/00", cmd_ready, HTRANS); end
        $display("txn reset released");
    endtask

    task automatic test_single_write();
        clear_tables();
        wq[0] = 32'h0000_A5A5;
        start_cmd(1'b1, 32'h5300_0000, 4'd0);
        checks++; if (o_ready[31] !== 1'b1) begin errors++;
            $display("FAIL sw_ready_idle: got %b expected 1", o_ready[31]); end
        run(4, 0);
        checks++; if (o_htrans[0] !== T_NONSEQ || o_haddr[0] !== 32'h5300_0000) begin errors++;
            $display("FAIL sw_nonseq: got %b/%h expected 10/53000000", o_htrans[0], o_haddr[0]); end
        checks++; if (o_hburst[0] !== 3'b000 || o_hwrite[0] !== 1'b1) begin errors++;
            $display("FAIL sw_ctrl: HBURST=%b HWRITE=%b expected 000/1", o_hburst[0], o_hwrite[0]); end
        checks++; if (o_pop[0] !== 1'b1 || n_pop != 1) begin errors++;
            $display("FAIL sw_pop: first=%b count=%0d expected 1/1", o_pop[0], n_pop); end
        checks++; if (o_htrans[1] !== T_IDLE || o_hwdata[1] !== 32'h0000_A5A5) begin errors++;
            $display("FAIL sw_data: HTRANS=%b HWDATA=%h expected 00/0000a5a5", o_htrans[1], o_hwdata[1]); end
        checks++; if (o_done[2] !== 1'b1 || o_ready[2] !== 1'b1 || n_done != 1) begin errors++;
            $display("FAIL sw_done: done@2=%b ready@2=%b count=%0d expected 1/1/1", o_done[2], o_ready[2], n_done); end
        checks++; if (o_rv[2] !== 1'b0 || o_err[2] !== 1'b0) begin errors++;
            $display("FAIL sw_flags: rdata_valid=%b err=%b expected 0/0", o_rv[2], o_err[2]); end
        $display("txn single_write addr=53000000 pops=%0d done=%0d", n_pop, n_done);
    endtask

    task automatic test_read_burst();
        logic [1:0]  eh [7] = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_IDLE, T_IDLE, T_IDLE};
        logic [31:0] ea;
        logic        erv;
        clear_tables();
        for (int k = 1; k <= 4; k++) t_rdata[k] = 32'h11 * 32'(k);
        start_cmd(1'b0, 32'h0000_0100, 4'd3);
        run(7, 3);  // cmd_valid stays high into the burst and must be ignored
        checks++; if (o_hburst[0] !== 3'b001 || o_hwrite[0] !== 1'b0) begin errors++;
            $display("FAIL rd_ctrl: HBURST=%b HWRITE=%b expected 001/0", o_hburst[0], o_hwrite[0]); end
        for (int c = 0; c < 7; c++) begin
            checks++; if (o_htrans[c] !== eh[c]) begin errors++;
                $display("FAIL rd_htrans[%0d]: got %b expected %b", c, o_htrans[c], eh[c]); end
            if (c < 4) begin
                ea = 32'h100 + 32'(4 * c);
                checks++; if (o_haddr[c] !== ea) begin errors++;
                    $display("FAIL rd_haddr[%0d]: got %h expected %h", c, o_haddr[c], ea); end
            end
            erv = (c >= 2 && c <= 5);
            checks++; if (o_rv[c] !== erv) begin errors++;
                $display("FAIL rd_valid[%0d]: got %b expected %b", c, o_rv[c], erv); end
            if (erv) begin
                ea = 32'h11 * 32'(c - 1);
                checks++; if (o_rdata[c] !== ea) begin errors++;
                    $display("FAIL rd_data[%0d]: got %h expected %h", c, o_rdata[c], ea); end
            end
            checks++; if (o_done[c] !== (c == 5) || o_ready[c] !== (c >= 5)) begin errors++;
                $display("FAIL rd_done[%0d]: done=%b ready=%b expected %b/%b", c, o_done[c], o_ready[c], c == 5, c >= 5); end
        end
        $display("txn read_burst addr=00000100 beats=4 rvalid=%0d done=%0d", n_rv, n_done);
    endtask

    task automatic test_write_wait();
        logic [1:0]  eh [9] = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_IDLE, T_IDLE, T_IDLE};
        logic [31:0] ea [6] = '{32'h2000, 32'h2004, 32'h2008, 32'h2008, 32'h2008, 32'h200C};
        logic [31:0] ew [6];
        logic        ep [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        clear_tables();
        for (int k = 0; k < 4; k++) wq[k] = 32'hC0DE_0010 + 32'(k);
        ew = '{32'hC0DE_0010, 32'hC0DE_0011, 32'hC0DE_0011, 32'hC0DE_0011, 32'hC0DE_0012, 32'hC0DE_0013};
        t_rdy[2] = 1'b0; t_rdy[3] = 1'b0;
        start_cmd(1'b1, 32'h0000_2000, 4'd3);
        run(9, 0);
        for (int c = 0; c < 9; c++) begin
            checks++; if (o_htrans[c] !== eh[c] || o_pop[c] !== ep[c]) begin errors++;
                $display("FAIL wr_cycle[%0d]: HTRANS=%b pop=%b expected %b/%b", c, o_htrans[c], o_pop[c], eh[c], ep[c]); end
            if (c < 6) begin
                checks++; if (o_haddr[c] !== ea[c]) begin errors++;
                    $display("FAIL wr_haddr[%0d]: got %h expected %h", c, o_haddr[c], ea[c]); end
            end
            if (c >= 1 && c <= 6) begin
                checks++; if (o_hwdata[c] !== ew[c - 1]) begin errors++;
                    $display("FAIL wr_hwdata[%0d]: got %h expected %h", c, o_hwdata[c], ew[c - 1]); end
            end
        end
        checks++; if (n_pop != 4 || n_done != 1 || o_done[7] !== 1'b1) begin errors++;
            $display("FAIL wr_totals: pops=%0d done=%0d done@7=%b expected 4/1/1", n_pop, n_done, o_done[7]); end
        $display("txn write_wait addr=00002000 beats=4 pops=%0d done=%0d", n_pop, n_done);
    endtask

    task automatic test_read_error();
        logic [1:0] eh [6] = '{T_NONSEQ, T_SEQ, T_SEQ, T_IDLE, T_IDLE, T_IDLE};
        clear_tables();
        t_rdata[1] = 32'h0000_00AA;
        t_rdy[2] = 1'b0; t_resp[2] = 1'b1; t_rdata[2] = 32'h0000_00BB;
        t_rdy[3] = 1'b1; t_resp[3] = 1'b1; t_rdata[3] = 32'h0000_00CC;
        start_cmd(1'b0, 32'h0000_0300, 4'd3);
        run(6, 0);
        for (int c = 0; c < 6; c++) begin
            checks++; if (o_htrans[c] !== eh[c]) begin errors++;
                $display("FAIL re_htrans[%0d]: got %b expected %b", c, o_htrans[c], eh[c]); end
            checks++; if (o_err[c] !== (c >= 4)) begin errors++;
                $display("FAIL re_err[%0d]: got %b expected %b", c, o_err[c], c >= 4); end
        end
        checks++; if (o_haddr[2] !== 32'h0000_0308) begin errors++;
            $display("FAIL re_haddr: got %h expected 00000308", o_haddr[2]); end
        checks++; if (n_rv != 1 || o_rv[2] !== 1'b1 || o_rdata[2] !== 32'h0000_00AA) begin errors++;
            $display("FAIL re_rvalid: count=%0d rv@2=%b rdata=%h expected 1/1/000000aa", n_rv, o_rv[2], o_rdata[2]); end
        checks++; if (n_done != 1 || o_done[4] !== 1'b1 || o_ready[4] !== 1'b1) begin errors++;
            $display("FAIL re_done: count=%0d done@4=%b ready@4=%b expected 1/1/1", n_done, o_done[4], o_ready[4]); end
        $display("txn read_error addr=00000300 rvalid=%0d err=%b done=%0d", n_rv, o_err[5], n_done);
    endtask

    task automatic test_addr_wrap();
        clear_tables();
        t_rdata[1] = 32'h0000_0005; t_rdata[2] = 32'h0000_0006;
        start_cmd(1'b0, 32'hFFFF_FFFF, 4'd1);
        checks++; if (o_err[31] !== 1'b1) begin errors++;
            $display("FAIL wrap_err_sticky: got %b expected 1", o_err[31]); end
        run(4, 0);
        checks++; if (o_err[0] !== 1'b0) begin errors++;
            $display("FAIL wrap_err_clear: got %b expected 0", o_err[0]); end
        checks++; if (o_htrans[0] !== T_NONSEQ || o_haddr[0] !== 32'hFFFF_FFFC) begin errors++;
            $display("FAIL wrap_first: got %b/%h expected 10/fffffffc", o_htrans[0], o_haddr[0]); end
        checks++; if (o_htrans[1] !== T_SEQ || o_haddr[1] !== 32'h0000_0000) begin errors++;
            $display("FAIL wrap_second: got %b/%h expected 11/00000000", o_htrans[1], o_haddr[1]); end
        checks++; if (o_hburst[0] !== 3'b001) begin errors++;
            $display("FAIL wrap_hburst: got %b expected 001", o_hburst[0]); end
        checks++; if (o_rdata[2] !== 32'h5 || o_rdata[3] !== 32'h6 || n_rv != 2 || o_done[3] !== 1'b1) begin errors++;
            $display("FAIL wrap_data: rdata=%h,%h rvalid=%0d done@3=%b expected 5,6/2/1", o_rdata[2], o_rdata[3], n_rv, o_done[3]); end
        $display("txn addr_wrap addr=fffffffc beats=2 rvalid=%0d", n_rv);
    endtask

    task automatic test_reset_midburst();
        clear_tables();
        for (int k = 0; k < 8; k++) wq[k] = 32'h8000_0000 + 32'(k);
        start_cmd(1'b1, 32'h0000_4000, 4'd7);
        run(4, 0);
        checks++; if (o_htrans[3] !== T_SEQ || o_haddr[3] !== 32'h0000_400C || o_hwdata[3] !== 32'h8000_0002) begin errors++;
            $display("FAIL rst_active: got %b/%h/%h expected 11/0000400c/80000002", o_htrans[3], o_haddr[3], o_hwdata[3]); end
        HRESET = 1'b1;
        #1;
        checks++; if ({HTRANS, HADDR, HWRITE, HBURST, HWDATA} !== '0) begin errors++;
            $display("FAIL rst_async_bus: got %h expected 0", {HTRANS, HADDR, HWRITE, HBURST, HWDATA}); end
        checks++; if ({rdata, rdata_valid, wdata_ready, done, err} !== '0) begin errors++;
            $display("FAIL rst_async_user: got %h expected 0", {rdata, rdata_valid, wdata_ready, done, err}); end
        @(negedge HCLK);
        HRESET = 1'b0;
        clear_tables();
        t_rdata[1] = 32'h0000_0077;
        start_cmd(1'b0, 32'h0000_0500, 4'd0);
        checks++; if (o_done[31] !== 1'b0 || o_ready[31] !== 1'b1 || o_htrans[31] !== T_IDLE) begin errors++;
            $display("FAIL rst_after: done=%b ready=%b HTRANS=%b expected 0/1/00", o_done[31], o_ready[31], o_htrans[31]); end
        run(4, 0);
        checks++; if (o_htrans[0] !== T_NONSEQ || o_haddr[0] !== 32'h0000_0500 || o_hburst[0] !== 3'b000 || o_hwrite[0] !== 1'b0) begin errors++;
            $display("FAIL rst_next_addr: got %b/%h/%b/%b expected 10/00000500/000/0", o_htrans[0], o_haddr[0], o_hburst[0], o_hwrite[0]); end
        checks++; if (o_htrans[1] !== T_IDLE || o_rv[2] !== 1'b1 || o_rdata[2] !== 32'h77 || o_done[2] !== 1'b1 || n_done != 1) begin errors++;
            $display("FAIL rst_next_data: HTRANS@1=%b rv=%b rdata=%h done=%b count=%0d expected 00/1/00000077/1/1", o_htrans[1], o_rv[2], o_rdata[2], o_done[2], n_done); end
        $display("txn reset_midburst then read addr=00000500 done=%0d", n_done);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) wq[k] = '0;
        test_reset();
        test_single_write();
        test_read_burst();
        test_write_wait();
        test_read_error();
        test_addr_wrap();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
